// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute unit: op codes, FSM states, widths.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT    = 32;
  localparam int unsigned SHAMT_W_DEFAULT = 5;
  localparam int unsigned OP_W            = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  // Op codes, identical to the alu_control encoding
  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SLL  = 4'b0001;
  localparam alu_op_t ALU_SLT  = 4'b0010;
  localparam alu_op_t ALU_SLTU = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SRA  = 4'b0110;
  localparam alu_op_t ALU_OR   = 4'b0111;
  localparam alu_op_t ALU_AND  = 4'b1000;
  localparam alu_op_t ALU_SUB  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_illegal(input alu_op_t op);
    return op > ALU_SUB;
  endfunction

  function automatic shift_kind_t shift_kind(input alu_op_t op);
    shift_kind_t k;
    k = SH_LL;
    if (op == ALU_SRL) k = SH_RL;
    if (op == ALU_SRA) k = SH_RA;
    return k;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between operand select, the execute unit and writeback.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
);
  logic                  in_valid;
  logic                  in_ready;
  logic [alu_pkg::OP_W-1:0] alu_op;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       result;
  logic                  zero;
  logic                  illegal_op;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: holds the working value and a down-counter, one bit per cycle.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  shift_kind_t        kind,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy_c,
  output logic               done_c,
  output logic [XLEN-1:0]    data,
  output logic [XLEN-1:0]    step_c
);

  logic [SHAMT_W-1:0] count;
  shift_kind_t        kind_q;

  assign busy_c = (count != '0);
  // Final step happens on the edge where count goes 1 -> 0
  assign done_c = (count == SHAMT_W'(1));

  always_comb begin
    step_c = data;
    case (kind_q)
      SH_LL:   step_c = {data[XLEN-2:0], 1'b0};
      SH_RL:   step_c = {1'b0, data[XLEN-1:1]};
      SH_RA:   step_c = {data[XLEN-1], data[XLEN-1:1]};
      default: step_c = data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data   <= '0;
      count  <= '0;
      kind_q <= SH_LL;
    end else if (load) begin
      data   <= data_in;
      count  <= shamt;
      kind_q <= kind;
    end else if (busy_c) begin
      data   <= step_c;
      count  <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle ALU ops inline, shifts via the serial shifter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_unit_if.slave  bus
);

  state_t state, state_next;

  logic               sh_load_c;
  logic               sh_busy_c;
  logic               sh_done_c;
  logic [XLEN-1:0]    sh_data;
  logic [XLEN-1:0]    sh_step_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [XLEN-1:0]    alu_c;

  logic [XLEN-1:0] result_nxt;
  logic            zero_nxt;
  logic            illegal_nxt;
  logic            out_valid_nxt;
  logic            in_ready_nxt;
  logic            load_result_c;

  assign shamt_c = bus.op_b[SHAMT_W-1:0];

  alu_serial_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sh_load_c),
    .kind    (shift_kind(bus.alu_op)),
    .data_in (bus.op_a),
    .shamt   (shamt_c),
    .busy_c  (sh_busy_c),
    .done_c  (sh_done_c),
    .data    (sh_data),
    .step_c  (sh_step_c)
  );

  // Single-cycle ops; shift codes are handled by the serial path
  always_comb begin
    alu_c = '0;
    case (bus.alu_op)
      ALU_ADD:  alu_c = bus.op_a + bus.op_b;
      ALU_SUB:  alu_c = bus.op_a - bus.op_b;
      ALU_SLT:  alu_c = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      ALU_SLTU: alu_c = XLEN'(bus.op_a < bus.op_b);
      ALU_XOR:  alu_c = bus.op_a ^ bus.op_b;
      ALU_OR:   alu_c = bus.op_a | bus.op_b;
      ALU_AND:  alu_c = bus.op_a & bus.op_b;
      default:  alu_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_shift(bus.alu_op) && (shamt_c != '0)) state_next = ST_SHIFT;
          else                                          state_next = ST_DONE;
        end
      end
      ST_SHIFT: if (sh_done_c || !sh_busy_c) state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready)           state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sh_load_c     = 1'b0;
    load_result_c = 1'b0;
    result_nxt    = bus.result;
    illegal_nxt   = bus.illegal_op;
    zero_nxt      = bus.zero;
    out_valid_nxt = (state_next == ST_DONE);
    in_ready_nxt  = (state_next == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          load_result_c = 1'b1;
          illegal_nxt   = is_illegal(bus.alu_op);
          if (is_illegal(bus.alu_op))  result_nxt = '0;
          else if (is_shift(bus.alu_op)) begin
            result_nxt = bus.op_a;
            sh_load_c  = (shamt_c != '0);
          end else                     result_nxt = alu_c;
        end
      end
      ST_SHIFT: begin
        if (state_next == ST_DONE) begin
          load_result_c = 1'b1;
          illegal_nxt   = 1'b0;
          result_nxt    = sh_done_c ? sh_step_c : sh_data;
        end
      end
      default: ;
    endcase
    if (load_result_c) zero_nxt = (result_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.result     <= '0;
      bus.zero       <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else begin
      bus.in_ready   <= in_ready_nxt;
      bus.out_valid  <= out_valid_nxt;
      bus.result     <= result_nxt;
      bus.zero       <= zero_nxt;
      bus.illegal_op <= illegal_nxt;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle integer execute unit: the consumer side of the 4-bit ALU operation code produced by alu_control.
- Accepts one operation (op code plus two XLEN operands) over a valid/ready handshake and returns the result over a valid/ready handshake.
- Shifts run serially, one bit per cycle; all other ops complete in one cycle.
- Sits between decode/operand-select and writeback in the multi-cycle datapath variant.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- alu_op  in  4  op code in alu_control encoding
- op_a  in  XLEN  operand A (rs1 / pc)
- op_b  in  XLEN  operand B (rs2 / imm); shift amount = op_b[SHAMT_W-1:0]
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal_op  out  1  alu_op was an unassigned code (qualified by out_valid)

Behaviour:
- Op encoding (shared package):
  - 0000 ADD, 1001 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU
  - 0100 XOR, 0101 SRL, 0110 SRA, 0111 OR, 1000 AND
  - 1010-1111 illegal.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; SLT/SLTU result is 1 or 0, zero-extended; SRA replicates op_a[XLEN-1].
- Illegal op: result = 0, zero = 1, illegal_op = 1, 1-cycle latency.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. Accept on in_valid & in_ready at edge E0; latch op, op_a, shamt.
    - Non-shift op, illegal op, or shamt = 0: go to DONE.
    - Shift op with shamt > 0: go to SHIFT, count = shamt.
  - SHIFT: each cycle shift the working register by one bit (SLL fills 0; SRL fills 0; SRA fills the sign bit) and decrement count. When count reaches 0, go to DONE.
  - DONE: out_valid = 1; result, zero and illegal_op are stable. On out_ready go to IDLE; otherwise hold all outputs unchanged (backpressure).
- Latency (accept edge to first cycle out_valid = 1): 1 cycle for non-shift ops; 1 + shamt cycles for shifts (maximum 32 at XLEN = 32).
- in_ready = 1 only in IDLE.
  - No acceptance while busy, or in the same cycle the result is consumed.
  - Minimum spacing between accepts is 2 cycles.
- Inputs are ignored outside IDLE; operands may change freely after acceptance.
- Reset (rst_n = 0 at an edge), from any state including mid-shift or DONE:
  - state goes to IDLE and the operation is discarded with no output;
  - out_valid = 0, result = 0, zero = 0, illegal_op = 0, count = 0;
  - in_ready = 1 from the first cycle after reset release.
- zero is derived from the registered result; it is valid only while out_valid = 1 and is 0 during reset.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 10 op codes, matching alu_control exactly;
  - the FSM state enum (IDLE/SHIFT/DONE);
  - XLEN and SHAMT_W defaults.
- One sub-module: alu_serial_shifter. It owns the working register and down-counter, has load/busy/done signals, and performs a 1-bit shift per cycle.
- Single-cycle ops stay inline in alu_exec_unit.

Test Plan:
- Reset then ADD: rst_n low 2 cycles, check in_ready = 1, out_valid = 0, result = 0. Issue ADD 0x7FFFFFFF + 1 -> out_valid the next cycle, result = 0x80000000, zero = 0.
- SUB equal and SLT signed:
  - SUB 5 - 5 -> result 0, zero = 1.
  - SLT 0xFFFFFFFF vs 1 -> result 1.
  - SLTU same operands -> result 0.
- Serial shifts, each out_valid exactly 1 + shamt cycles after accept:
  - SRA 0x80000000 by 4 -> 0xF8000000 after 5 cycles.
  - SLL 1 by 31 -> 0x80000000 after 32 cycles.
  - SRL by 0 -> 1 cycle.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE -> result, out_valid and zero stable, in_ready = 0. Raise out_ready -> in_ready = 1 the next cycle.
- Illegal op 1100 with op_a = 3, op_b = 4 -> result 0, zero = 1, illegal_op = 1, 1-cycle latency.
- Reset mid-operation: start SLL by 20, assert rst_n = 0 at cycle 7 -> no out_valid ever for that op. After release, ADD 2 + 3 -> result 5.
